// File: rtl/filtered_frame_buffer_pkg.sv
// Shared geometry defaults and read-FSM encoding
// for the ping-pong filtered frame store.
package filtered_frame_buffer_pkg;

  localparam int unsigned DEF_IMAGE_WIDTH    = 8;
  localparam int unsigned DEF_IMAGE_HEIGHT   = 8;
  localparam int unsigned DEF_PIXEL_WIDTH    = 8;
  localparam int unsigned DEF_DROP_CNT_WIDTH = 8;

  localparam int unsigned FRAME_PIXELS =
    DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

  function automatic int unsigned cnt_width(
    input int unsigned pixels
  );
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(FRAME_PIXELS);

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/filtered_frame_buffer_if.sv
// Pixel-in / frame-out bundle of the frame store;
// slave is the buffer side, master the environment.
interface filtered_frame_buffer_if
  import filtered_frame_buffer_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
);

  logic                      in_valid;
  logic [PIXEL_WIDTH-1:0]    in_data;
  logic                      in_frame_complete;
  logic                      out_ready;
  logic                      out_valid;
  logic [PIXEL_WIDTH-1:0]    out_data;
  logic                      out_last;
  logic                      overflow;
  logic                      frame_err;
  logic [DROP_CNT_WIDTH-1:0] frames_dropped;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_frame_complete,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last,
    output overflow,
    output frame_err,
    output frames_dropped
  );

  modport master (
    output in_valid,
    output in_data,
    output in_frame_complete,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  overflow,
    input  frame_err,
    input  frames_dropped
  );

endinterface

// File: rtl/filtered_frame_buffer_frame_bank_ram.sv
// Simple dual-port RAM holding both frame banks;
// address is {bank, index}, read data is registered.
module frame_bank_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register doubles as the hold stage
  // while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/filtered_frame_buffer.sv
// Ping-pong capture of a backpressure-free pixel stream
// with valid/ready frame replay and drop/sync detection.
module filtered_frame_buffer
  import filtered_frame_buffer_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH    = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT   = DEF_IMAGE_HEIGHT,
  parameter int unsigned PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  filtered_frame_buffer_if.slave bus_io
);

  localparam int unsigned NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CW   = cnt_width(NPIX);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

  logic                      wr_bank_q, wr_bank_d;
  logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
  logic                      drop_q, drop_d;
  logic [1:0]                full_q, full_d, full_eff;
  logic                      ovf_q, ovf_d;
  logic                      err_q, err_d;
  logic [DROP_CNT_WIDTH-1:0] drops_q, drops_d;

  rd_state_e                 st_q, st_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [CW-1:0]             rd_idx_q, rd_idx_d;

  logic                      rd_last, release_rd;
  logic                      wr_first, wr_last;
  logic                      sync_bad, store_px, we;
  logic                      re;
  logic [CW:0]               raddr;
  logic [PIXEL_WIDTH-1:0]    rdata;

  frame_bank_ram #(
    .DW (PIXEL_WIDTH),
    .AW (CW + 1)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i ({wr_bank_q, wr_cnt_q}),
    .wdata_i (bus_io.in_data),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign rd_last    = (rd_idx_q == LAST_IDX);
  assign release_rd = (st_q == RD_STREAM)
                   && bus_io.out_ready && rd_last;

  always_comb begin
    st_d      = st_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    re        = 1'b0;
    raddr     = {rd_bank_q, rd_idx_q};
    unique case (st_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          st_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        re       = 1'b1;
        raddr    = {rd_bank_q, {CW{1'b0}}};
        rd_idx_d = '0;
        st_d     = RD_STREAM;
      end
      RD_STREAM: begin
        if (bus_io.out_ready) begin
          if (rd_last) begin
            rd_bank_d = ~rd_bank_q;
            st_d = full_q[~rd_bank_q] ? RD_FETCH
                                      : RD_IDLE;
          end else begin
            re       = 1'b1;
            raddr    = {rd_bank_q, rd_idx_q + 1'b1};
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: st_d = RD_IDLE;
    endcase
  end

  // A bank freed by the reader this cycle is
  // already available to a starting frame.
  always_comb begin
    full_eff = full_q;
    if (release_rd) begin
      full_eff[rd_bank_q] = 1'b0;
    end
  end

  assign wr_first = (wr_cnt_q == '0);
  assign wr_last  = (wr_cnt_q == LAST_IDX);
  assign sync_bad = bus_io.in_frame_complete
                 && !(bus_io.in_valid && wr_last);
  assign store_px = wr_first ? !full_eff[wr_bank_q]
                             : !drop_q;
  assign we = bus_io.in_valid && !sync_bad && store_px;

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    drop_d    = drop_q;
    full_d    = full_eff;
    ovf_d     = ovf_q;
    err_d     = err_q;
    drops_d   = drops_q;
    if (sync_bad) begin
      err_d    = 1'b1;
      wr_cnt_d = '0;
      drop_d   = 1'b0;
    end else if (bus_io.in_valid) begin
      drop_d = !store_px;
      if (wr_last) begin
        wr_cnt_d = '0;
        if (store_px) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          ovf_d = 1'b1;
          if (drops_q != '1) begin
            drops_d = drops_q + 1'b1;
          end
        end
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      drop_q    <= 1'b0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      drops_q   <= '0;
      st_q      <= RD_IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      drop_q    <= drop_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      drops_q   <= drops_d;
      st_q      <= st_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  assign bus_io.out_valid      = (st_q == RD_STREAM);
  assign bus_io.out_data       = rdata;
  assign bus_io.out_last       = (st_q == RD_STREAM) && rd_last;
  assign bus_io.overflow       = ovf_q;
  assign bus_io.frame_err      = err_q;
  assign bus_io.frames_dropped = drops_q;

endmodule

// File: tb/tb_filtered_frame_buffer.sv
// Scoreboard bench for filtered_frame_buffer: frame-level
// model of a two-slot store, decoupled output monitor.
module tb_filtered_frame_buffer;
  import filtered_frame_buffer_pkg::*;

  localparam int NPIX = FRAME_PIXELS;
  localparam int DCW  = 2;
  localparam int DMAX = (1 << DCW) - 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  filtered_frame_buffer_if #(
    .PIXEL_WIDTH(8), .DROP_CNT_WIDTH(DCW)
  ) b ();

  filtered_frame_buffer #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8),
    .PIXEL_WIDTH(8), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(b)
  );

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int out_frames = 0;
  int stored = 0;
  int rdy_mode = 1;
  int pat_i = 0;
  bit exp_ovf = 0;
  bit exp_err = 0;
  int exp_drops = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin : mon
    beat_t e;
    bit held;
    logic [7:0] held_d;
    logic held_l;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          chk("valid_hold", b.out_valid, 1);
          chk("data_hold", b.out_data, held_d);
          chk("last_hold", b.out_last, held_l);
        end
        held = 0;
        if (b.out_valid && b.out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h want none",
                     b.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", b.out_data, e.data);
            chk("out_last", b.out_last, e.last);
            if (e.last) out_frames++;
          end
        end else if (b.out_valid) begin
          held = 1;
          held_d = b.out_data;
          held_l = b.out_last;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle(input logic v, input logic [7:0] d,
                       input logic fc, input bit nr);
    logic r;
    case (rdy_mode)
      0: r = 1'b0;
      1: r = 1'b1;
      2: begin
        r = (pat_i == 0) || (pat_i == 3);
        pat_i = (pat_i + 1) % 4;
      end
      default: r = ($urandom_range(0, 1) == 1);
    endcase
    if (nr) r = 1'b0;
    b.in_valid = v;
    b.in_data = d;
    b.in_frame_complete = fc;
    b.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 8'h00, 0, 0);
  endtask

  // A frame is kept iff fewer than two captured frames
  // are still unread when its first pixel arrives.
  task automatic send_frame(input logic [7:0] base,
                            input bit rnd,
                            input int err_at,
                            input bit err_pix,
                            input int gap_pct);
    logic [7:0] px [NPIX];
    bit acc;
    for (int i = 0; i < NPIX; i++)
      px[i] = rnd ? 8'($urandom) : 8'(base + i);
    acc = (stored - out_frames) < 2;
    for (int i = 0; i < NPIX; i++) begin
      if (gap_pct > 0 && i > 0)
        while ($urandom_range(0, 99) < gap_pct)
          cycle(0, 8'h00, 0, 0);
      if (i == err_at) begin
        cycle(err_pix, px[i], 1, !acc && i == 0);
        exp_err = 1;
        return;
      end
      cycle(1, px[i], i == NPIX - 1, !acc && i == 0);
    end
    if (acc) begin
      for (int i = 0; i < NPIX; i++)
        exp_q.push_back(beat_t'{data: px[i],
                                last: (i == NPIX - 1)});
      stored++;
    end else begin
      exp_ovf = 1;
      if (exp_drops < DMAX) exp_drops++;
    end
  endtask

  task automatic drain(input int mode);
    int n;
    n = 0;
    rdy_mode = mode;
    while (exp_q.size() != 0 && n < 3000) begin
      cycle(0, 8'h00, 0, 0);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overflow"}, b.overflow, exp_ovf);
    chk({tag, "_frame_err"}, b.frame_err, exp_err);
    chk({tag, "_dropped"}, b.frames_dropped, exp_drops);
  endtask

  initial begin : stim
    bit seen;
    int hs0;
    int n;
    b.in_valid = 0;
    b.in_data = 0;
    b.in_frame_complete = 0;
    b.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", b.out_valid, 0);
    chk("rst_last", b.out_last, 0);
    chk("rst_data", b.out_data, 0);
    check_flags("rst");
    rst_n = 1;
    idle(2);

    rdy_mode = 1;
    send_frame(8'h00, 0, -1, 0, 0);
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      idle(1);
      if (b.out_valid) seen = 1;
    end
    chk("t1_latency", seen, 1);
    drain(1);
    check_flags("t1");

    hs0 = hs_cnt;
    rdy_mode = 2;
    pat_i = 0;
    send_frame(8'h00, 0, -1, 0, 0);
    drain(2);
    chk("t2_handshakes", hs_cnt - hs0, NPIX);
    check_flags("t2");

    rdy_mode = 0;
    send_frame(8'h00, 0, -1, 0, 0);
    send_frame(8'h40, 0, -1, 0, 0);
    send_frame(8'h80, 0, -1, 0, 0);
    idle(3);
    check_flags("t3");
    drain(1);

    rdy_mode = 1;
    send_frame(8'h20, 0, 21, 0, 0);
    idle(4);
    check_flags("t4a");
    send_frame(8'hA0, 0, -1, 0, 0);
    send_frame(8'h30, 0, 0, 1, 0);
    send_frame(8'hC0, 0, -1, 0, 0);
    drain(1);
    check_flags("t4");

    rdy_mode = 0;
    send_frame(8'h01, 0, -1, 0, 0);
    send_frame(8'h41, 0, -1, 0, 0);
    for (int f = 0; f < 5; f++)
      send_frame(8'(8'h90 + f), 0, -1, 0, 0);
    idle(2);
    check_flags("t5");
    drain(1);

    rdy_mode = 0;
    send_frame(8'h10, 0, -1, 0, 0);
    rdy_mode = 1;
    hs0 = hs_cnt;
    n = 0;
    while (hs_cnt - hs0 < 30 && n < 200) begin
      idle(1);
      n++;
    end
    chk("t6_reach", hs_cnt - hs0, 30);
    chk("t6_px30", b.out_data, 8'h10 + 8'd30);
    rst_n = 0;
    #1;
    chk("t6_valid", b.out_valid, 0);
    chk("t6_last", b.out_last, 0);
    chk("t6_ovf", b.overflow, 0);
    chk("t6_err", b.frame_err, 0);
    chk("t6_drops", b.frames_dropped, 0);
    exp_q.delete();
    stored = out_frames;
    exp_ovf = 0;
    exp_err = 0;
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(2);
    chk("t6_idle_valid", b.out_valid, 0);
    send_frame(8'h55, 0, -1, 0, 0);
    drain(1);
    check_flags("t6");

    rdy_mode = 3;
    for (int f = 0; f < 14; f++) begin
      int ea;
      ea = ($urandom_range(0, 5) == 0)
         ? int'($urandom_range(0, 62)) : -1;
      send_frame(8'h00, 1, ea,
                 $urandom_range(0, 1) == 1, 20);
      idle($urandom_range(0, 3));
    end
    drain(1);
    check_flags("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
